// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
//   Bundles every handshake and datapath signal of alu_share_arbiter:
//   two request channels (valid/ready + operands + op), two response
//   channels (valid/ready) with shared result/zero/err, the registered
//   operand/control bus to the shared ALU and the ALU's result/zero.
//
//   modport slave  : the arbiter's view
//   modport master : the requester/ALU side (testbench or surrounding logic)
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
);
    // request channels
    logic              req0_valid;
    logic              req1_valid;
    logic              req0_ready;
    logic              req1_ready;
    logic [WIDTH-1:0]  req0_a;
    logic [WIDTH-1:0]  req0_b;
    logic [WIDTH-1:0]  req1_a;
    logic [WIDTH-1:0]  req1_b;
    logic [CTRL_W-1:0] req0_op;
    logic [CTRL_W-1:0] req1_op;

    // response channels
    logic              rsp0_valid;
    logic              rsp1_valid;
    logic              rsp0_ready;
    logic              rsp1_ready;
    logic [WIDTH-1:0]  rsp_result;
    logic              rsp_zero;
    logic              rsp_err;

    // shared ALU
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_zero;

    // status
    logic              busy;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_op, req1_op, rsp0_ready, rsp1_ready, alu_result, alu_zero,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result,
               rsp_zero, rsp_err, alu_a, alu_b, alu_ctrl, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_op, req1_op, rsp0_ready, rsp1_ready, alu_result, alu_zero,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result,
               rsp_zero, rsp_err, alu_a, alu_b, alu_ctrl, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one combinational RV32I ALU between two requesters. One operation
//   is in flight at a time: IDLE (arbitrate/accept) -> EXEC (ALU settles,
//   result captured) -> RESP (held until the owner's rsp_ready).
//   Round-robin: on contention the requester that did not win last time wins.
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      alu_share_arbiter_if.slave: request/response channels, ALU
//            operand/control outputs, ALU result/zero inputs, busy
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alu_share_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_reg;
    logic              owner_reg;
    logic              last_grant_reg;
    logic [WIDTH-1:0]  alu_a_reg;
    logic [WIDTH-1:0]  alu_b_reg;
    logic [CTRL_W-1:0] alu_ctrl_reg;
    logic [WIDTH-1:0]  rsp_result_reg;
    logic              rsp_zero_reg;
    logic              rsp_err_reg;
    logic [1:0]        rsp_valid_reg;
    logic              busy_reg;

    // Channel-indexed views of the request/response signals
    logic [1:0]                  req_valid;
    logic [1:0]                  rsp_ready;
    logic [1:0][WIDTH-1:0]       req_a;
    logic [1:0][WIDTH-1:0]       req_b;
    logic [1:0][CTRL_W-1:0]      req_op;
    logic [1:0]                  grant;
    logic                        winner;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
    assign req_a     = {bus.req1_a,  bus.req0_a};
    assign req_b     = {bus.req1_b,  bus.req0_b};
    assign req_op    = {bus.req1_op, bus.req0_op};

    // A requester wins if it is the only one asking, or if both ask and the
    // other one was granted last. At most one grant bit can be set.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = req_valid[gi] &
                               (~req_valid[1-gi] | (last_grant_reg != 1'(gi)));
        end
    endgenerate

    assign winner = grant[1];

    function automatic logic op_supported(input logic [CTRL_W-1:0] op);
        return (op == CTRL_W'(4'b0000)) || (op == CTRL_W'(4'b0001)) ||
               (op == CTRL_W'(4'b0010)) || (op == CTRL_W'(4'b0110));
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;     // req0 wins the first contention
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_ctrl_reg   <= '0;
            rsp_result_reg <= '0;
            rsp_zero_reg   <= 1'b0;
            rsp_err_reg    <= 1'b0;
            rsp_valid_reg  <= 2'b00;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        alu_a_reg      <= req_a[winner];
                        alu_b_reg      <= req_b[winner];
                        alu_ctrl_reg   <= req_op[winner];
                        owner_reg      <= winner;
                        last_grant_reg <= winner;
                        busy_reg       <= 1'b1;
                        state_reg      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Operands were stable for the whole cycle; capture the ALU.
                    rsp_result_reg <= bus.alu_result;
                    rsp_zero_reg   <= bus.alu_zero;
                    rsp_err_reg    <= ~op_supported(alu_ctrl_reg);
                    rsp_valid_reg  <= owner_reg ? 2'b10 : 2'b01;
                    state_reg      <= ST_RESP;
                end
                ST_RESP: begin
                    // Only the owner's ready matters; the other is ignored.
                    if (rsp_ready[owner_reg]) begin
                        rsp_valid_reg <= 2'b00;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg <= 2'b00;
                    busy_reg      <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready is combinational so a request is accepted in the same IDLE cycle.
    assign bus.req0_ready = (state_reg == ST_IDLE) & grant[0];
    assign bus.req1_ready = (state_reg == ST_IDLE) & grant[1];

    assign bus.rsp0_valid = rsp_valid_reg[0];
    assign bus.rsp1_valid = rsp_valid_reg[1];
    assign bus.rsp_result = rsp_result_reg;
    assign bus.rsp_zero   = rsp_zero_reg;
    assign bus.rsp_err    = rsp_err_reg;
    assign bus.alu_a      = alu_a_reg;
    assign bus.alu_b      = alu_b_reg;
    assign bus.alu_ctrl   = alu_ctrl_reg;
    assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Drives the arbiter with directed and random two-requester traffic and a
//   behavioural ALU, checking handshakes, latency, results and round-robin
//   order against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

    logic clk;
    logic reset_n;

    alu_share_arbiter_if #(.WIDTH(32), .CTRL_W(4)) bus ();

    alu_share_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int last_grant_m = 1;
    int txn_cnt = 0;

    // --- reference arithmetic ---
    function automatic bit ref_supported(input logic [3:0] op);
        return (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0010) || (op == 4'b0110);
    endfunction

    function automatic logic [31:0] ref_result(input logic [3:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural ALU hanging off the arbiter's operand bus
    assign bus.alu_result = ref_result(bus.alu_ctrl, bus.alu_a, bus.alu_b);
    assign bus.alu_zero   = ref_supported(bus.alu_ctrl) &&
                            (ref_result(bus.alu_ctrl, bus.alu_a, bus.alu_b) == 32'd0);

    // Round-robin expectation: -1 none, else requester index
    function automatic int exp_grant(input bit v0, input bit v1);
        if (v0 && v1) return 1 - last_grant_m;
        if (v0)       return 0;
        if (v1)       return 1;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
        check({tag, "_rsp0v"}, 32'(bus.rsp0_valid), 32'd0);
        check({tag, "_rsp1v"}, 32'(bus.rsp1_valid), 32'd0);
        check({tag, "_res"},   bus.rsp_result, 32'd0);
        check({tag, "_zero"},  32'(bus.rsp_zero), 32'd0);
        check({tag, "_err"},   32'(bus.rsp_err), 32'd0);
        check({tag, "_alua"},  bus.alu_a, 32'd0);
        check({tag, "_alub"},  bus.alu_b, 32'd0);
        check({tag, "_ctrl"},  32'(bus.alu_ctrl), 32'd0);
    endtask

    // One complete transaction, entered and left at a negedge.
    task automatic run_op(input bit v0, input bit v1,
                          input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
                          input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1,
                          input int stall, input bit keep_loser);
        int w;
        int g;
        logic [31:0] ea, eb, er;
        logic [3:0]  eo;
        bit          ez, ee;

        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
        w = exp_grant(v0, v1);
        #1;
        check("idle_ready0", 32'(bus.req0_ready), 32'(w == 0));
        check("idle_ready1", 32'(bus.req1_ready), 32'(w == 1));
        if (w < 0) begin
            @(negedge clk);
            return;
        end

        @(posedge clk);
        last_grant_m = w;
        ea = (w == 1) ? a1 : a0;
        eb = (w == 1) ? b1 : b0;
        eo = (w == 1) ? op1 : op0;
        er = ref_result(eo, ea, eb);
        ee = !ref_supported(eo);
        ez = !ee && (er == 32'd0);

        @(negedge clk);
        // winner withdraws; the loser either keeps waiting or gives up
        if (w == 0) begin
            bus.req0_valid = 1'b0;
            if (!keep_loser) bus.req1_valid = 1'b0;
        end else begin
            bus.req1_valid = 1'b0;
            if (!keep_loser) bus.req0_valid = 1'b0;
        end
        #1;
        check("exec_ready0", 32'(bus.req0_ready), 32'd0);
        check("exec_ready1", 32'(bus.req1_ready), 32'd0);
        check("exec_busy",   32'(bus.busy), 32'd1);
        check("exec_rsp0v",  32'(bus.rsp0_valid), 32'd0);
        check("exec_rsp1v",  32'(bus.rsp1_valid), 32'd0);
        check("exec_alua",   bus.alu_a, ea);
        check("exec_alub",   bus.alu_b, eb);
        check("exec_ctrl",   32'(bus.alu_ctrl), 32'(eo));

        @(negedge clk);
        for (int i = 0; i <= stall; i++) begin
            bus.rsp0_ready = (w == 0) ? (i == stall) : 1'($urandom_range(0, 1));
            bus.rsp1_ready = (w == 1) ? (i == stall) : 1'($urandom_range(0, 1));
            #1;
            check("resp_rsp0v",  32'(bus.rsp0_valid), 32'(w == 0));
            check("resp_rsp1v",  32'(bus.rsp1_valid), 32'(w == 1));
            check("resp_result", bus.rsp_result, er);
            check("resp_zero",   32'(bus.rsp_zero), 32'(ez));
            check("resp_err",    32'(bus.rsp_err), 32'(ee));
            check("resp_busy",   32'(bus.busy), 32'd1);
            check("resp_ready0", 32'(bus.req0_ready), 32'd0);
            check("resp_ready1", 32'(bus.req1_ready), 32'd0);
            @(negedge clk);
        end
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        #1;
        // back in IDLE: a waiting loser must now be offered the grant
        g = exp_grant(bus.req0_valid, bus.req1_valid);
        check("post_busy",   32'(bus.busy), 32'd0);
        check("post_rsp0v",  32'(bus.rsp0_valid), 32'd0);
        check("post_rsp1v",  32'(bus.rsp1_valid), 32'd0);
        check("post_ready0", 32'(bus.req0_ready), 32'(g == 0));
        check("post_ready1", 32'(bus.req1_ready), 32'(g == 1));
        txn_cnt++;
        $display("txn %0d req%0d a=%h b=%h op=%h -> result=%h zero=%0d err=%0d stall=%0d",
                 txn_cnt, w, ea, eb, eo, er, ez, ee, stall);
    endtask

    // Reset asserted while an operation is in flight.
    task automatic reset_mid_op(input bit in_resp);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 32'h11; bus.req1_b = 32'h22; bus.req1_op = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        if (in_resp) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_all_zero(in_resp ? "rst_resp" : "rst_exec");
        last_grant_m = 1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_after_rsp0v", 32'(bus.rsp0_valid), 32'd0);
            check("rst_after_rsp1v", 32'(bus.rsp1_valid), 32'd0);
            check("rst_after_busy",  32'(bus.busy), 32'd0);
        end
        $display("txn reset during %s", in_resp ? "RESP" : "EXEC");
        // contention straight after reset goes to req0
        run_op(1'b1, 1'b1, 32'd3, 32'd4, 4'b0010, 32'd8, 32'd1, 4'b0110, 0, 1'b0);
    endtask

    function automatic logic [3:0] pick_op();
        int s;
        s = $urandom_range(0, 9);
        case (s)
            0, 1:    return 4'b0000;
            2, 3:    return 4'b0001;
            4, 5:    return 4'b0010;
            6, 7:    return 4'b0110;
            8:       return 4'b0111;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        bit v0, v1;
        logic [31:0] a0, b0, a1, b1;

        reset_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        check("reset_ready0", 32'(bus.req0_ready), 32'd0);
        check("reset_ready1", 32'(bus.req1_ready), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // directed cases
        run_op(1'b1, 1'b0, 32'd5, 32'd7, 4'b0010, 32'd0, 32'd0, 4'b0000, 0, 1'b0);
        run_op(1'b0, 1'b1, 32'd0, 32'd0, 4'b0000, 32'h1234, 32'h1234, 4'b0110, 0, 1'b0);
        run_op(1'b0, 1'b1, 32'd0, 32'd0, 4'b0000, 32'd9, 32'd4, 4'b0110, 0, 1'b0);
        run_op(1'b1, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 32'd0, 32'd0, 4'b0000, 5, 1'b0);
        run_op(1'b1, 1'b0, 32'd1, 32'd1, 4'b0111, 32'd0, 32'd0, 4'b0000, 0, 1'b0);
        // sustained contention: strict alternation
        repeat (4)
            run_op(1'b1, 1'b1, 32'd10, 32'd20, 4'b0010, 32'd30, 32'd40, 4'b0001, 0, 1'b1);

        reset_mid_op(1'b0);
        reset_mid_op(1'b1);

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1 && ($urandom_range(0, 3) != 0)) v1 = 1'b1;
            a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            a1 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            run_op(v0, v1, a0, b0, pick_op(), a1, b1, pick_op(),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
